// File: rtl/wfid_free_list.sv
// Circular free list of wavefront IDs. Allocation pops entry[head] into a registered
// grant; release pushes an ID at the tail. Both pointers wrap from NUM_WF-1 to 0.
module wfid_free_list #(
  parameter int unsigned NUM_WF = 40,
  parameter int unsigned ID_W   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_req,
  input  logic            release_valid,
  input  logic [ID_W-1:0] release_wfid,
  output logic            alloc_ack,
  output logic [ID_W-1:0] alloc_wfid,
  output logic [ID_W-1:0] free_count,
  output logic            empty,
  output logic            full,
  output logic            err
);

  localparam logic [ID_W-1:0] LastIdx  = ID_W'(NUM_WF - 1);
  localparam logic [ID_W-1:0] MaxCount = ID_W'(NUM_WF);

  logic [ID_W-1:0] entry_q [NUM_WF];

  logic [ID_W-1:0] head_q, head_d;
  logic [ID_W-1:0] tail_q, tail_d;
  logic [ID_W-1:0] count_q, count_d;
  logic            ack_q, ack_d;
  logic [ID_W-1:0] wfid_q, wfid_d;
  logic            err_q, err_d;

  logic grant;
  logic rel_legal;
  logic rel_illegal;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] ptr);
    return (ptr == LastIdx) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    grant       = alloc_req && (count_q != '0);
    // A full list can still accept a release when a grant frees a slot in the same cycle.
    rel_legal   = release_valid && (release_wfid < MaxCount) &&
                  ((count_q != MaxCount) || grant);
    rel_illegal = release_valid && !rel_legal;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ack_d   = 1'b0;
    wfid_d  = wfid_q;
    err_d   = err_q | rel_illegal;

    if (grant) begin
      ack_d  = 1'b1;
      wfid_d = entry_q[head_q];
      head_d = next_ptr(head_q);
    end

    if (rel_legal) begin
      tail_d = next_ptr(tail_q);
    end

    unique case ({rel_legal, grant})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= MaxCount;
      ack_q   <= 1'b0;
      wfid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      wfid_q  <= wfid_d;
      err_q   <= err_d;
    end
  end

  // Storage write uses the pre-edge head read above, so alloc+release at head==tail
  // grants the old entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WF; i++) begin
        entry_q[i] <= ID_W'(i);
      end
    end else if (rel_legal) begin
      entry_q[tail_q] <= release_wfid;
    end
  end

  assign alloc_ack  = ack_q;
  assign alloc_wfid = wfid_q;
  assign free_count = count_q;
  assign empty      = (count_q == '0);
  assign full       = (count_q == MaxCount);
  assign err        = err_q;

endmodule
